// File: rtl/ps2_rx_fifo_pkg.sv
// ps2_pkg: shared constants, types and helpers for the PS/2 receive path.
//   PS2_PREFIX_EXT / PS2_PREFIX_BRK : scan-code prefixes folded into flags
//   PS2_FRAME_BITS                  : start + 8 data + parity + stop
//   ps2_entry_t                     : one queued result {ext, brk, code}
//   ps2_state_t                     : deframer FSM states
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } ps2_state_t;

  // Frame layout: [0]=start, [8:1]=data LSB first, [9]=odd parity, [10]=stop.
  function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead head output.
//   clk, clrn    : clock, asynchronous active-low reset
//   push, wdata  : write request and data (dropped when full unless popping)
//   pop          : remove head entry (ignored when empty)
//   full, empty  : occupancy flags
//   level        : current occupancy, 0..DEPTH
//   head         : oldest entry, forced to 0 while empty
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push & (~full | pop_ok);
  assign level_d = level_q + LW'(push_ok) - LW'(pop_ok);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  // Gating with empty keeps the output defined (and 0 after reset).
  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with prefix folding and FIFO.
//   clk, clrn          : system clock, asynchronous active-low reset
//   ps2_clk, ps2_data  : asynchronous PS/2 pins
//   rd_en              : pop head entry (ignored while valid=0)
//   clr_err            : clear sticky error flags (a same-cycle set wins)
//   valid, data, ext, brk, level : FIFO head and occupancy
//   overflow, parity_err, frame_err : sticky error flags
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 50000,
  parameter int COOKED     = 1
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic                          valid,
  output logic [7:0]                    data,
  output logic                          ext,
  output logic                          brk,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic filt_q, filt_d, strobe_q, strobe_d;
  logic [FCW-1:0] flt_cnt_q, flt_cnt_d;

  ps2_state_t                state_q, state_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
  logic [WDW-1:0]            wdog_q, wdog_d;
  logic                      ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic                      overflow_q, parity_err_q, frame_err_q;
  logic                      push, perr_set, ferr_set, ovf_set;
  logic                      fifo_full, fifo_empty;
  logic [7:0]                code;
  ps2_entry_t                push_entry, head_entry;

  // Filtered clock moves only once the new level has been seen FILTER_LEN times in a row.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (flt_cnt_q == FCW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                                   flt_cnt_d = flt_cnt_q + FCW'(1);
    end
    strobe_d = filt_q & ~filt_d;
  end

  assign code = frame_q[8:1];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    wdog_d     = wdog_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    push       = 1'b0;
    push_entry = '0;
    perr_set   = 1'b0;
    ferr_set   = 1'b0;
    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (strobe_q) begin
          frame_d    = '0;
          frame_d[0] = dat_s2_q;
          bit_cnt_d  = 4'd1;
          state_d    = RECV;
        end
      end
      RECV: begin
        if (strobe_q) begin
          frame_d[bit_cnt_q] = dat_s2_q;
          wdog_d             = '0;
          if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) state_d = CHECK;
          else                                     bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          // Device stalled mid-frame: abandon it and resynchronise on the next start bit.
          ferr_set   = 1'b1;
          frame_d    = '0;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          wdog_d     = '0;
          state_d    = IDLE;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (ps2_frame_ok(frame_q)) begin
          if (COOKED != 0 && code == PS2_PREFIX_EXT) begin
            ext_pend_d = 1'b1;
          end else if (COOKED != 0 && code == PS2_PREFIX_BRK) begin
            brk_pend_d = 1'b1;
          end else begin
            push       = 1'b1;
            push_entry = '{ext: ext_pend_q, brk: brk_pend_q, code: code};
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end
        end else begin
          perr_set   = 1'b1;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Full implies valid, so rd_en alone decides whether the slot is freed.
  assign ovf_set = push & fifo_full & ~rd_en;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      filt_q       <= 1'b1;
      flt_cnt_q    <= '0;
      strobe_q     <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      frame_q      <= '0;
      wdog_q       <= '0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_s1_q     <= ps2_clk;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= ps2_data;
      dat_s2_q     <= dat_s1_q;
      filt_q       <= filt_d;
      flt_cnt_q    <= flt_cnt_d;
      strobe_q     <= strobe_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_q      <= frame_d;
      wdog_q       <= wdog_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      overflow_q   <= ovf_set  | (overflow_q   & ~clr_err);
      parity_err_q <= perr_set | (parity_err_q & ~clr_err);
      frame_err_q  <= ferr_set | (frame_err_q  & ~clr_err);
    end
  end

  sync_fifo #(
    .WIDTH ($bits(ps2_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .wdata (push_entry),
    .pop   (rd_en),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level),
    .head  (head_entry)
  );

  assign valid      = ~fifo_empty;
  assign data       = head_entry.code;
  assign ext        = head_entry.ext;
  assign brk        = head_entry.brk;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule
